// File: rtl/stream_cmd_pkg.sv
// stream_cmd_pkg: command/response byte codes and FSM states for stream_cmd_responder.
package stream_cmd_pkg;
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;
    typedef enum logic [2:0] {
        IDLE,
        ARGS,
        BUS_WR,
        BUS_RD,
        RD_WAIT,
        RESP
    } state_e;
endpackage

// File: rtl/stream_cmd_responder.sv
// stream_cmd_responder: byte-stream command parser issuing 16-bit bus reads/writes and streaming back a response.
module stream_cmd_responder
    import stream_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 480000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [15:0] bus_rdata
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic          cmd_wr_q, cmd_wr_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   resp_q, resp_d;
    logic          more_q, more_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          bus_we_q, bus_we_d;
    logic          bus_re_q, bus_re_d;
    logic          in_acc, out_acc;

    assign in_acc    = in_valid && in_ready_q;
    assign out_acc   = out_valid_q && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign bus_we    = bus_we_q;
    assign bus_re    = bus_re_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cmd_wr_d = cmd_wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        resp_d   = resp_q;
        more_d   = more_q;
        tmo_d    = '0;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (in_acc) begin
                    cmd_wr_d = in_data == CMD_WR;
                    state_d  = (in_data == CMD_WR || in_data == CMD_RD) ? ARGS : RESP;
                    resp_d   = {RSP_NAK, 8'h00};
                    more_d   = 1'b0;
                end
            end
            ARGS: begin
                if (in_acc) begin
                    idx_d   = idx_q + 2'd1;
                    addr_d  = idx_q == 2'd0 ? {in_data, addr_q[7:0]} :
                              idx_q == 2'd1 ? {addr_q[15:8], in_data} : addr_q;
                    wdata_d = idx_q == 2'd2 ? {in_data, wdata_q[7:0]} :
                              idx_q == 2'd3 ? {wdata_q[15:8], in_data} : wdata_q;
                    if (idx_q == (cmd_wr_q ? 2'd3 : 2'd1))
                        state_d = cmd_wr_q ? BUS_WR : BUS_RD;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            BUS_WR: begin
                resp_d  = {RSP_ACK, 8'h00};
                more_d  = 1'b0;
                state_d = RESP;
            end
            BUS_RD: state_d = RD_WAIT;
            RD_WAIT: begin
                resp_d  = bus_rdata;
                more_d  = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (out_acc) begin
                    resp_d  = {resp_q[7:0], 8'h00};
                    more_d  = 1'b0;
                    state_d = more_q ? RESP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with state_q.
        in_ready_d  = state_d == IDLE || state_d == ARGS;
        out_valid_d = state_d == RESP;
        out_data_d  = state_d == RESP ? resp_d[15:8] : 8'h00;
        bus_we_d    = state_d == BUS_WR;
        bus_re_d    = state_d == BUS_RD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cmd_wr_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_q      <= '0;
            more_q      <= 1'b0;
            tmo_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            bus_we_q    <= 1'b0;
            bus_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cmd_wr_q    <= cmd_wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_q      <= resp_d;
            more_q      <= more_d;
            tmo_q       <= tmo_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            bus_we_q    <= bus_we_d;
            bus_re_q    <= bus_re_d;
        end
    end
endmodule

// File: tb/tb_stream_cmd_responder.sv
// tb_stream_cmd_responder: directed self-checking bench for stream_cmd_responder.
module tb_stream_cmd_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_we, bus_re;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0, re_cnt = 0, both_cnt = 0;
    logic [15:0] we_addr = '0, we_data = '0, re_addr = '0;
    logic [7:0] out_q[$];

    stream_cmd_responder #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus_rdata <= bus_re ? (bus_addr == 16'h0010 ? 16'hA55A : 16'h1357) : 16'hxxxx;
        if (bus_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= bus_addr;
            we_data <= bus_wdata;
        end
        if (bus_re) begin
            re_cnt  <= re_cnt + 1;
            re_addr <= bus_addr;
        end
        if (bus_we && bus_re) both_cnt <= both_cnt + 1;
        if (out_valid && out_ready) out_q.push_back(out_data);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_out(input int target, input string tag);
        int n = 0;
        while (out_q.size() < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, out_q.size(), target);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, in_ready, 1);
    endtask

    initial begin
        int ob, wb, rb;
        logic vh, dh, rl;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_re", bus_re, 0);
        chk("rst_bus_addr", bus_addr, 16'h0000);
        chk("rst_bus_wdata", bus_wdata, 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        chk("first_in_ready", in_ready, 1);

        ob = out_q.size(); wb = we_cnt; rb = re_cnt;
        send(8'h57); send(8'h12); send(8'h34); send(8'hBE); send(8'hEF);
        wait_out(ob + 1, "wr_resp_cnt");
        chk("wr_we_pulses", we_cnt - wb, 1);
        chk("wr_addr", we_addr, 16'h1234);
        chk("wr_data", we_data, 16'hBEEF);
        chk("wr_no_re", re_cnt - rb, 0);
        chk("wr_ack", out_q[ob], 8'h06);
        chk("wr_hold_addr", bus_addr, 16'h1234);
        chk("wr_hold_wdata", bus_wdata, 16'hBEEF);
        wait_ready("wr_ready_back");

        ob = out_q.size(); wb = we_cnt; rb = re_cnt;
        send(8'h52); send(8'h00); send(8'h10);
        wait_out(ob + 2, "rd_resp_cnt");
        chk("rd_re_pulses", re_cnt - rb, 1);
        chk("rd_addr", re_addr, 16'h0010);
        chk("rd_no_we", we_cnt - wb, 0);
        chk("rd_hi", out_q[ob], 8'hA5);
        chk("rd_lo", out_q[ob + 1], 8'h5A);
        wait_ready("rd_ready_back");

        ob = out_q.size(); wb = we_cnt; rb = re_cnt;
        send(8'h41);
        wait_out(ob + 1, "nak_cnt");
        chk("nak_byte", out_q[ob], 8'h15);
        chk("nak_no_strobe", (we_cnt - wb) + (re_cnt - rb), 0);
        wait_ready("nak_ready_back");

        ob = out_q.size(); wb = we_cnt; rb = re_cnt;
        send(8'h57); send(8'h12);
        repeat (100) @(negedge clk);
        chk("tmo_no_out", out_q.size() - ob, 0);
        chk("tmo_no_strobe", (we_cnt - wb) + (re_cnt - rb), 0);
        send(8'h52); send(8'h00); send(8'h00);
        wait_out(ob + 2, "tmo_rd_cnt");
        chk("tmo_no_we", we_cnt - wb, 0);
        chk("tmo_rd_addr", re_addr, 16'h0000);
        chk("tmo_rd_hi", out_q[ob], 8'h13);
        chk("tmo_rd_lo", out_q[ob + 1], 8'h57);
        wait_ready("tmo_ready_back");

        ob = out_q.size();
        out_ready = 1'b0;
        send(8'h52); send(8'h00); send(8'h10);
        repeat (5) @(negedge clk);
        vh = 1'b1; dh = 1'b1; rl = 1'b1;
        repeat (500) begin
            @(negedge clk);
            vh &= out_valid;
            dh &= (out_data == 8'hA5);
            rl &= !in_ready;
        end
        chk("stall_valid_held", vh, 1);
        chk("stall_data_stable", dh, 1);
        chk("stall_in_ready_low", rl, 1);
        chk("stall_no_out", out_q.size() - ob, 0);
        out_ready = 1'b1;
        wait_out(ob + 2, "stall_cnt");
        chk("stall_hi", out_q[ob], 8'hA5);
        chk("stall_lo", out_q[ob + 1], 8'h5A);
        wait_ready("stall_ready_back");

        ob = out_q.size(); wb = we_cnt;
        send(8'h57); send(8'h12); send(8'h34); send(8'hBE);
        #2 rst = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 0);
        chk("arst_bus_addr", bus_addr, 16'h0000);
        chk("arst_bus_wdata", bus_wdata, 16'h0000);
        chk("arst_out_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(8'hEF);
        wait_out(ob + 1, "arst_resp_cnt");
        chk("arst_nak", out_q[ob], 8'h15);
        repeat (20) @(negedge clk);
        chk("arst_no_we", we_cnt - wb, 0);
        chk("never_both", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stream_cmd_responder.md
STREAM_CMD_RESPONDER -- requirements
Module: stream_cmd_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 480000, meaning the inter-byte gap in clk cycles after which a partial command is discarded (10 ms at 48 MHz).
REQ-002 SHALL have port clk  input  1  system clock (48 MHz USB clock domain).
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_data  input  8  host-to-device byte (from USB serial out pipeline).
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port out_data  output  8  device-to-host response byte (to USB serial in pipeline).
REQ-008 SHALL have port out_valid  output  1  out_data valid.
REQ-009 SHALL have port out_ready  input  1  sink accepts out_data this cycle.
REQ-010 SHALL have port bus_addr  output  16  bus word address.
REQ-011 SHALL have port bus_wdata  output  16  bus write data.
REQ-012 SHALL have port bus_we  output  1  one-cycle write strobe.
REQ-013 SHALL have port bus_re  output  1  one-cycle read strobe.
REQ-014 SHALL have port bus_rdata  input  16  read data, valid exactly one cycle after bus_re.

Function
REQ-015 SHALL transfer a byte on either stream only in a cycle where valid and ready are both high.
REQ-016 SHALL implement states IDLE, ARGS, BUS_WR, BUS_RD, RD_WAIT, RESP.
REQ-017 SHALL in IDLE assert in_ready; on accepted 0x57 ('W') go to ARGS expecting 4 bytes, on 0x52 ('R') go to ARGS expecting 2 bytes, on any other byte load response 0x15 (NAK, 1 byte) and go to RESP.
REQ-018 SHALL in ARGS assert in_ready and capture bytes big-endian: addr_hi, addr_lo, then (write only) data_hi, data_lo.
REQ-019 SHALL after the last argument byte go to BUS_WR (write) or BUS_RD (read) on the next cycle.
REQ-020 SHALL in BUS_WR pulse bus_we for exactly one cycle with bus_addr/bus_wdata stable, load response 0x06 (ACK, 1 byte), go to RESP.
REQ-021 SHALL in BUS_RD pulse bus_re for one cycle, then in RD_WAIT sample bus_rdata, load response {rdata[15:8], rdata[7:0]} (2 bytes, high first), go to RESP.
REQ-022 SHALL in RESP hold out_valid high with out_data stable until out_ready, advance to the next byte per transfer, return to IDLE after the final transfer.
REQ-023 SHALL deassert in_ready in BUS_WR, BUS_RD, RD_WAIT, RESP (no input buffering; backpressure only).
REQ-024 SHALL count idle cycles in ARGS (reset on every accepted byte); on reaching TIMEOUT_CYCLES return to IDLE with no bus access and no response.
REQ-025 SHALL not time out while in RESP regardless of out_ready stall length.
REQ-026 SHALL keep bus_addr and bus_wdata holding their last captured value outside strobes; bus_we and bus_re never high simultaneously.
REQ-027 SHALL accept back-to-back commands: first byte of the next command accepted the cycle after returning to IDLE.

Reset
REQ-028 SHALL on rst low immediately force state IDLE, in_ready 0, out_valid 0, out_data 0x00, bus_we 0, bus_re 0, bus_addr 0x0000, bus_wdata 0x0000, timeout counter 0.
REQ-029 SHALL assert in_ready in the first clk edge after rst deasserts; reset mid-command or mid-response discards it with no partial bus strobe.

Structure
REQ-030 SHALL place command codes (0x57, 0x52), response codes (0x06, 0x15) and the state enumeration in shared package stream_cmd_pkg.
REQ-031 SHALL be a single module; the timeout counter is width clog2(TIMEOUT_CYCLES+1) and inline, no sub-module.

Verification
REQ-032 SHALL cover: send 57 12 34 BE EF, out_ready=1 -> one bus_we pulse addr 0x1234 wdata 0xBEEF, then out byte 0x06.
REQ-033 SHALL cover: bus model returns 0xA55A at 0x0010; send 52 00 10 -> bus_re one cycle at 0x0010, out bytes A5 then 5A.
REQ-034 SHALL cover: send 0x41 -> out 0x15, no bus strobe, in_ready back high after transfer.
REQ-035 SHALL cover: send 57 12 then silence with TIMEOUT_CYCLES=100 -> after 100 cycles IDLE, no strobe, no output; then 52 00 00 answered normally.
REQ-036 SHALL cover: read response with out_ready low 500 cycles -> out_valid held, out_data stable at high byte, in_ready low throughout, bytes delivered once out_ready rises.
REQ-037 SHALL cover: rst asserted after 57 12 34 BE -> outputs at reset values asynchronously; after release, no bus_we ever issued for the aborted command.
